// File: rtl/mac_pipe.sv
// Three-stage unsigned multiply-add/accumulate: S = A*B + C or S = ACC + A*B.
// Result 3 edges after acceptance; a stalled output (out_valid && !out_ready) freezes the whole pipe.
module mac_pipe #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int C_W   = 8,
  parameter int ACC_W = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [C_W-1:0]   c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] s,
  output logic             ovf
);

  localparam int P_W = A_W + B_W;

  logic             s1_vld_q, s1_vld_d;
  logic [A_W-1:0]   s1_a_q, s1_a_d;
  logic [B_W-1:0]   s1_b_q, s1_b_d;
  logic [C_W-1:0]   s1_c_q, s1_c_d;
  logic [1:0]       s1_mode_q, s1_mode_d;

  logic             s2_vld_q, s2_vld_d;
  logic [P_W-1:0]   s2_p_q, s2_p_d;
  logic [C_W-1:0]   s2_c_q, s2_c_d;
  logic [1:0]       s2_mode_q, s2_mode_d;

  logic             out_vld_q, out_vld_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic             stall;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] res;

  assign stall     = out_vld_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_vld_q;
  assign s         = s_q;
  assign ovf       = ovf_q;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_c_d    = s1_c_q;
    s1_mode_d = s1_mode_q;
    s2_vld_d  = s2_vld_q;
    s2_p_d    = s2_p_q;
    s2_c_d    = s2_c_q;
    s2_mode_d = s2_mode_q;
    out_vld_d = out_vld_q;
    s_d       = s_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    sum       = '0;
    res       = '0;

    if (!stall) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_c_d    = c;
        s1_mode_d = mode;
      end

      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_p_d    = P_W'(s1_a_q) * P_W'(s1_b_q);
        s2_c_d    = s1_c_q;
        s2_mode_d = s1_mode_q;
      end

      // Bubbles leave s, ovf and the accumulator untouched; only out_valid drops.
      out_vld_d = s2_vld_q;
      if (s2_vld_q) begin
        case (s2_mode_q)
          2'b00, 2'b10: sum = (ACC_W+1)'(s2_p_q) + (ACC_W+1)'(s2_c_q);
          2'b01:        sum = {1'b0, acc_q} + (ACC_W+1)'(s2_p_q);
          default:      sum = '0;
        endcase
        res   = (sum[ACC_W] && (SAT != 0)) ? '1 : sum[ACC_W-1:0];
        s_d   = res;
        ovf_d = sum[ACC_W];
        if (s2_mode_q != 2'b00) acc_d = res;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_c_q    <= '0;
      s1_mode_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_p_q    <= '0;
      s2_c_q    <= '0;
      s2_mode_q <= '0;
      out_vld_q <= 1'b0;
      s_q       <= '0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_c_q    <= s1_c_d;
      s1_mode_q <= s1_mode_d;
      s2_vld_q  <= s2_vld_d;
      s2_p_q    <= s2_p_d;
      s2_c_q    <= s2_c_d;
      s2_mode_q <= s2_mode_d;
      out_vld_q <= out_vld_d;
      s_q       <= s_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: default (wrap), saturating and wide instances run in lockstep against an arithmetic model.
// Latency checked as 3 edges from acceptance to out_valid.
// Backpressure exercised with out_ready low windows and random out_ready.
`timescale 1ns/1ps
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic [15:0] c_i = '0;

  logic        ir0, ov0, ovf0, ir1, ov1, ovf1, ir2, ov2, ovf2;
  logic [7:0]  s0, s1;
  logic [15:0] s2;

  int checks = 0;
  int failures = 0;
  int tick_n = 0;
  int acc0 = 0, acc1 = 0, acc2 = 0;

  logic [16:0] exp0[$], exp1[$], exp2[$], got0[$], got1[$], got2[$];
  int          gt0[$];

  logic        d_acc;
  logic [2:0]  d_ir, d_ov;
  logic [7:0]  d_s;

  always #5 clk = ~clk;

  mac_pipe #(.A_W(4), .B_W(4), .C_W(8), .ACC_W(8), .SAT(0)) u0 (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
    .a(a_i[3:0]), .b(b_i[3:0]), .c(c_i[7:0]), .mode(mode),
    .out_valid(ov0), .out_ready(out_ready), .s(s0), .ovf(ovf0));

  mac_pipe #(.A_W(4), .B_W(4), .C_W(8), .ACC_W(8), .SAT(1)) u1 (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
    .a(a_i[3:0]), .b(b_i[3:0]), .c(c_i[7:0]), .mode(mode),
    .out_valid(ov1), .out_ready(out_ready), .s(s1), .ovf(ovf1));

  mac_pipe #(.A_W(8), .B_W(8), .C_W(16), .ACC_W(16), .SAT(0)) u2 (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
    .a(a_i), .b(b_i), .c(c_i), .mode(mode),
    .out_valid(ov2), .out_ready(out_ready), .s(s2), .ovf(ovf2));

  // Reference: operands truncated to the instance widths, plain integer arithmetic.
  task automatic model_step(input int aw, input int bw, input int cw, input int accw, input int sat,
                            input logic [1:0] m, input int ta, input int tbv, input int tc,
                            inout int accv, output logic [16:0] r);
    int mask, p, cc, sum, res;
    logic o;
    mask = (1 << accw) - 1;
    p    = (ta & ((1 << aw) - 1)) * (tbv & ((1 << bw) - 1));
    cc   = tc & ((1 << cw) - 1);
    case (m)
      2'b00:   sum = p + cc;
      2'b01:   sum = accv + p;
      2'b10:   sum = p + cc;
      default: sum = 0;
    endcase
    o   = (sum > mask);
    res = o ? (sat != 0 ? mask : (sum & mask)) : sum;
    if (m != 2'b00) accv = res;
    r = {o, 16'(res)};
  endtask

  // One clock: drive at negedge, sample just after, record accepted and consumed beats.
  task automatic tick(input logic v, input logic [1:0] m, input logic [7:0] ta, input logic [7:0] tbb,
                      input logic [15:0] tc, input logic ordy, output logic acc_o,
                      output logic [2:0] ir, output logic [2:0] ov, output logic [7:0] so);
    logic [16:0] r;
    @(negedge clk);
    in_valid = v; mode = m; a_i = ta; b_i = tbb; c_i = tc; out_ready = ordy;
    #1;
    ir = {ir2, ir1, ir0};
    ov = {ov2, ov1, ov0};
    so = s0;
    acc_o = v && ir0;
    if (acc_o) begin
      model_step(4, 4, 8, 8, 0, m, int'(ta), int'(tbb), int'(tc), acc0, r); exp0.push_back(r);
      model_step(4, 4, 8, 8, 1, m, int'(ta), int'(tbb), int'(tc), acc1, r); exp1.push_back(r);
      model_step(8, 8, 16, 16, 0, m, int'(ta), int'(tbb), int'(tc), acc2, r); exp2.push_back(r);
    end
    if (ov0 && ordy) begin got0.push_back({ovf0, 8'h00, s0}); gt0.push_back(tick_n); end
    if (ov1 && ordy) got1.push_back({ovf1, 8'h00, s1});
    if (ov2 && ordy) got2.push_back({ovf2, s2});
    @(posedge clk);
    tick_n++;
  endtask

  task automatic drain();
    repeat (6) tick(1'b0, 2'b00, 8'h00, 8'h00, 16'h0000, 1'b1, d_acc, d_ir, d_ov, d_s);
  endtask

  task automatic flush_queues();
    exp0.delete(); exp1.delete(); exp2.delete();
    got0.delete(); got1.delete(); got2.delete(); gt0.delete();
  endtask

  task automatic test_reset();
    logic acc_o;
    logic [2:0] ir, ov;
    logic [7:0] so;
    #1 clear = 1'b1;
    #2;
    checks++;
    if ({ov0, ovf0, s0, ir0, ov2, s2} !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_state got ov=%0b ovf=%0b s=%0d ir=%0b ov2=%0b s2=%0d exp 0,0,0,1,0,0",
               ov0, ovf0, s0, ir0, ov2, s2);
    end
    @(negedge clk) clear = 1'b0;
    repeat (3) tick(1'b1, 2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 16'($urandom),
                    1'b1, acc_o, ir, ov, so);
    #2 clear = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({ov0, ovf0, s0, ir0, ov1, ov2} !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_midstream got ov=%0b ovf=%0b s=%0d ir=%0b exp 0,0,0,1", ov0, ovf0, s0, ir0);
    end
    flush_queues();
    acc0 = 0; acc1 = 0; acc2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) clear = 1'b0;
    tick(1'b1, 2'b00, 8'd2, 8'd3, 16'd1, 1'b1, acc_o, ir, ov, so);
    checks++;
    if (acc_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_accept got=%0b exp=1", acc_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1, acc_o, ir, ov, so);
      checks++;
      if (ov[0] !== 1'b0) begin
        failures++;
        $display("FAIL reset_early_valid cycle=%0d got=%0b exp=0", i, ov[0]);
      end
    end
    tick(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1, acc_o, ir, ov, so);
    checks++;
    if ({ov[0], so} !== {1'b1, 8'd7}) begin
      failures++;
      $display("FAIL reset_latency got ov=%0b s=%0d exp ov=1 s=7", ov[0], so);
    end
    drain();
    checks++;
    if (got0.size() !== 1 || got0[0] !== {1'b0, 16'd7}) begin
      failures++;
      $display("FAIL reset_no_stale got n=%0d first=%0h exp n=1 first=7", got0.size(), got0[0]);
    end
    flush_queues();
  endtask

  task automatic test_mac_stream();
    logic acc_o;
    logic [2:0] ir, ov;
    logic [7:0] so;
    tick(1'b1, 2'b00, 8'd15, 8'd15, 16'd10, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b00, 8'd15, 8'd15, 16'd255, 1'b1, acc_o, ir, ov, so);
    drain();
    checks++;
    if (got0.size() !== 2 || got0[0] !== {1'b0, 16'd235} || got0[1] !== {1'b1, 16'd224}) begin
      failures++;
      $display("FAIL mac_wrap got %0h %0h exp 000eb 100e0", got0[0], got0[1]);
    end
    checks++;
    if (gt0[1] - gt0[0] !== 1) begin
      failures++;
      $display("FAIL mac_consecutive got gap=%0d exp 1", gt0[1] - gt0[0]);
    end
    checks++;
    if ({got0.size(), got1.size(), got2.size()} !== {exp0.size(), exp1.size(), exp2.size()}) begin
      failures++;
      $display("FAIL mac_count got %0d/%0d/%0d exp %0d/%0d/%0d", got0.size(), got1.size(), got2.size(),
               exp0.size(), exp1.size(), exp2.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      checks++;
      if ({got0[i], got1[i], got2[i]} !== {exp0[i], exp1[i], exp2[i]}) begin
        failures++;
        $display("FAIL mac_model beat=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got0[i], got1[i], got2[i],
                 exp0[i], exp1[i], exp2[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_saturate();
    logic acc_o;
    logic [2:0] ir, ov;
    logic [7:0] so;
    tick(1'b1, 2'b10, 8'd15, 8'd15, 16'd255, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b01, 8'd1, 8'd1, 16'd0, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b01, 8'd0, 8'd0, 16'd0, 1'b1, acc_o, ir, ov, so);
    drain();
    checks++;
    if (got1.size() !== 3 || got1[0] !== {1'b1, 16'd255} || got1[1] !== {1'b1, 16'd255} ||
        got1[2] !== {1'b0, 16'd255}) begin
      failures++;
      $display("FAIL sat_values got %0h %0h %0h exp 100ff 100ff 000ff", got1[0], got1[1], got1[2]);
    end
    checks++;
    if ({got0.size(), got1.size(), got2.size()} !== {exp0.size(), exp1.size(), exp2.size()}) begin
      failures++;
      $display("FAIL sat_count got %0d/%0d/%0d exp %0d/%0d/%0d", got0.size(), got1.size(), got2.size(),
               exp0.size(), exp1.size(), exp2.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      checks++;
      if ({got0[i], got1[i], got2[i]} !== {exp0[i], exp1[i], exp2[i]}) begin
        failures++;
        $display("FAIL sat_model beat=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got0[i], got1[i], got2[i],
                 exp0[i], exp1[i], exp2[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_acc_chain();
    logic acc_o;
    logic [2:0] ir, ov;
    logic [7:0] so;
    int e[6] = '{5, 17, 21, 28, 0, 1};
    tick(1'b1, 2'b10, 8'd0, 8'd0, 16'd5, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b01, 8'd3, 8'd4, 16'd0, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b01, 8'd2, 8'd2, 16'd0, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b01, 8'd1, 8'd7, 16'd0, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b11, 8'd9, 8'd9, 16'd99, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b01, 8'd1, 8'd1, 16'd0, 1'b1, acc_o, ir, ov, so);
    drain();
    checks++;
    if (got0.size() !== 6) begin
      failures++;
      $display("FAIL chain_count got=%0d exp=6", got0.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got0[i] !== {1'b0, 16'(e[i])}) begin
        failures++;
        $display("FAIL chain_value beat=%0d got=%0h exp=%0d", i, got0[i], e[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gt0[i+1] - gt0[i] !== 1) begin
        failures++;
        $display("FAIL chain_gap beat=%0d got=%0d exp=1", i, gt0[i+1] - gt0[i]);
      end
    end
    for (int i = 0; i < exp0.size(); i++) begin
      checks++;
      if ({got0[i], got1[i], got2[i]} !== {exp0[i], exp1[i], exp2[i]}) begin
        failures++;
        $display("FAIL chain_model beat=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got0[i], got1[i], got2[i],
                 exp0[i], exp1[i], exp2[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_backpressure();
    logic acc_o, ordy, prev_stall;
    logic [2:0] ir, ov;
    logic [7:0] so, prev_s;
    logic [1:0] bm[6];
    logic [7:0] ba[6], bb[6];
    logic [15:0] bc[6];
    int idx;
    for (int i = 0; i < 6; i++) begin
      bm[i] = 2'($urandom_range(0, 2)); ba[i] = 8'($urandom); bb[i] = 8'($urandom); bc[i] = 16'($urandom);
    end
    idx = 0; prev_stall = 1'b0; prev_s = '0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      ordy = !(cyc >= 4 && cyc <= 6);
      if (idx < 6) tick(1'b1, bm[idx], ba[idx], bb[idx], bc[idx], ordy, acc_o, ir, ov, so);
      else         tick(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, ordy, acc_o, ir, ov, so);
      if (acc_o) idx++;
      checks++;
      if (ir !== ~(ov & {3{~ordy}})) begin
        failures++;
        $display("FAIL bp_in_ready cycle=%0d got=%b ov=%b ordy=%0b", cyc, ir, ov, ordy);
      end
      if (prev_stall) begin
        checks++;
        if (so !== prev_s) begin
          failures++;
          $display("FAIL bp_hold cycle=%0d got=%0d exp=%0d", cyc, so, prev_s);
        end
      end
      prev_stall = ov[0] && !ordy;
      prev_s = so;
    end
    checks++;
    if (idx !== 6 || got0.size() !== 6) begin
      failures++;
      $display("FAIL bp_count got acc=%0d out=%0d exp 6/6", idx, got0.size());
    end
    checks++;
    if ({got0.size(), got1.size(), got2.size()} !== {exp0.size(), exp1.size(), exp2.size()}) begin
      failures++;
      $display("FAIL bp_sizes got %0d/%0d/%0d exp %0d/%0d/%0d", got0.size(), got1.size(), got2.size(),
               exp0.size(), exp1.size(), exp2.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      checks++;
      if ({got0[i], got1[i], got2[i]} !== {exp0[i], exp1[i], exp2[i]}) begin
        failures++;
        $display("FAIL bp_model beat=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got0[i], got1[i], got2[i],
                 exp0[i], exp1[i], exp2[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_param_sweep();
    logic acc_o;
    logic [2:0] ir, ov;
    logic [7:0] so;
    tick(1'b1, 2'b00, 8'd255, 8'd255, 16'd510, 1'b1, acc_o, ir, ov, so);
    tick(1'b1, 2'b00, 8'd255, 8'd255, 16'd511, 1'b1, acc_o, ir, ov, so);
    drain();
    checks++;
    if (got2.size() !== 2 || got2[0] !== {1'b0, 16'hffff} || got2[1] !== {1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL wide_values got %0h %0h exp 0ffff 10000", got2[0], got2[1]);
    end
    for (int i = 0; i < exp0.size(); i++) begin
      checks++;
      if ({got0[i], got1[i], got2[i]} !== {exp0[i], exp1[i], exp2[i]}) begin
        failures++;
        $display("FAIL wide_model beat=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got0[i], got1[i], got2[i],
                 exp0[i], exp1[i], exp2[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_random();
    logic acc_o, v, ordy;
    logic [2:0] ir, ov;
    logic [7:0] so;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      tick(v, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 16'($urandom), ordy, acc_o, ir, ov, so);
      checks++;
      if (ir !== ~(ov & {3{~ordy}})) begin
        failures++;
        $display("FAIL rand_in_ready cycle=%0d got=%b ov=%b ordy=%0b", cyc, ir, ov, ordy);
      end
    end
    drain();
    checks++;
    if ({got0.size(), got1.size(), got2.size()} !== {exp0.size(), exp1.size(), exp2.size()}) begin
      failures++;
      $display("FAIL rand_count got %0d/%0d/%0d exp %0d/%0d/%0d", got0.size(), got1.size(), got2.size(),
               exp0.size(), exp1.size(), exp2.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      checks++;
      if ({got0[i], got1[i], got2[i]} !== {exp0[i], exp1[i], exp2[i]}) begin
        failures++;
        $display("FAIL rand_model beat=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", i, got0[i], got1[i], got2[i],
                 exp0[i], exp1[i], exp2[i]);
      end
    end
    flush_queues();
  endtask

  initial begin
    test_reset();
    test_mac_stream();
    test_saturate();
    test_acc_chain();
    test_backpressure();
    test_param_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
